// File: rtl/vram_port_if.sv
// Bus bundle between the VRAM arbiter, the display fetch, the pixel writer and the frame RAM.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface vram_port_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 6
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              starve_err;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    output disp_data, disp_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata, starve_err
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    input  disp_data, disp_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata, starve_err
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single-port frame RAM arbiter: display reads always win, writes wait in a
// 2-entry FIFO and drain on idle cycles; a sticky watchdog flags starved writes.
module vram_port_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 6,
  parameter int MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  vram_port_if.slave bus
);
  localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fifo_addr [2];
  logic [DATA_W-1:0] fifo_data [2];
  logic              head, tail;
  logic [1:0]        count;
  logic              full, empty, push, pop;
  logic [CNT_W-1:0]  wait_cnt, wait_nxt;
  logic              starve;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              vld_p1, vld_p2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + 1'b1;
  endfunction

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  // No bypass: a full FIFO refuses a push even when it pops on the same edge.
  assign push  = bus.wr_valid && !full;

  always_comb begin
    state_nxt = IDLE;
    pop       = 1'b0;
    if (bus.disp_req) begin
      state_nxt = RD;
    end else if (!empty) begin
      state_nxt = WR;
      pop       = 1'b1;
    end
  end

  always_comb begin
    wait_nxt = '0;
    if (!empty && !pop) wait_nxt = sat_inc(wait_cnt);
  end

  // Stage p1: issue register driving the RAM port
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      state <= state_nxt;
      case (state_nxt)
        RD: addr_p1 <= bus.disp_addr;
        WR: begin
          addr_p1  <= fifo_addr[head];
          wdata_p1 <= fifo_data[head];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      count    <= count + {1'b0, push} - {1'b0, pop};
      wait_cnt <= wait_nxt;
      if (wait_nxt == WAIT_MAX) starve <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= bus.wr_addr;
      fifo_data[tail] <= bus.wr_data;
    end
  end

  // Stage p2: read valid aligned with RAM output data
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= bus.disp_req;
      vld_p2 <= vld_p1;
    end
  end

  assign bus.ram_en     = (state != IDLE);
  assign bus.ram_we     = (state == WR);
  assign bus.ram_addr   = addr_p1;
  assign bus.ram_wdata  = wdata_p1;
  assign bus.disp_valid = vld_p2;
  assign bus.disp_data  = vld_p2 ? bus.ram_rdata : '0;
  assign bus.wr_ready   = !full;
  assign bus.starve_err = starve;
endmodule
